// File: rtl/fft_bit_rev_reorder.sv
// Converts FFT output from bit-reversed to natural order using two ping-pong banks.
// Write side places each sample at bitrev(position); read side drains a full bank 0..N-1.
module fft_bit_rev_reorder #(
  parameter  int WIDTH  = 25,
  parameter  int N      = 1024,
  localparam int ADDR_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    valid_i,
  input  logic                    start_i,
  input  logic signed [WIDTH-1:0] x_re_i,
  input  logic signed [WIDTH-1:0] x_im_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] z_re_o,
  output logic signed [WIDTH-1:0] z_im_o,
  output logic [ADDR_W-1:0]       idx_o,
  output logic                    last_o,
  output logic                    frame_err_o
);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  // Both banks share one array; the bank select is the top address bit.
  logic [2*WIDTH-1:0] mem [2*N];
  logic [2*WIDTH-1:0] rd_data_q;

  wstate_t           ws_q, ws_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              wbank_q, wbank_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              done;

  rstate_t           rs_q, rs_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic              rbank_q, rbank_d;
  logic              re;

  logic              rd_v_q, rd_v_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;

  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;
  logic signed [WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;

  always_comb begin
    ws_d    = ws_q;
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    we      = 1'b0;
    waddr   = '0;
    err_d   = 1'b0;
    done    = 1'b0;
    if (valid_i) begin
      unique case (ws_q)
        W_IDLE: begin
          if (start_i) begin
            we     = 1'b1;
            wcnt_d = ADDR_W'(1);
            ws_d   = W_FILL;
          end
        end
        W_FILL: begin
          we = 1'b1;
          if (start_i) begin
            wcnt_d = ADDR_W'(1);
            err_d  = 1'b1;
          end else begin
            waddr  = bitrev(wcnt_q);
            wcnt_d = wcnt_q + ADDR_W'(1);
            if (wcnt_q == LAST_ADDR) begin
              done    = 1'b1;
              wbank_d = ~wbank_q;
              ws_d    = W_IDLE;
              wcnt_d  = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A completion may land on the final drain cycle of the other bank; it restarts the drain seamlessly.
  always_comb begin
    rs_d    = rs_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    re      = 1'b0;
    if (rs_q == R_DRAIN) begin
      re     = 1'b1;
      rcnt_d = rcnt_q + ADDR_W'(1);
      if (rcnt_q == LAST_ADDR) rs_d = R_IDLE;
    end
    if (done) begin
      rs_d    = R_DRAIN;
      rcnt_d  = '0;
      rbank_d = wbank_q;
    end
  end

  always_comb begin
    rd_v_d   = re;
    rd_idx_d = rcnt_q;
    valid_d  = rd_v_q;
    last_d   = rd_v_q && (rd_idx_q == LAST_ADDR);
    z_re_d   = z_re_q;
    z_im_d   = z_im_q;
    idx_d    = idx_q;
    if (rd_v_q) begin
      z_re_d = rd_data_q[2*WIDTH-1:WIDTH];
      z_im_d = rd_data_q[WIDTH-1:0];
      idx_d  = rd_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wbank_q, waddr}] <= {x_re_i, x_im_i};
    if (re) rd_data_q <= mem[{rbank_q, rcnt_q}];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ws_q     <= W_IDLE;
      wcnt_q   <= '0;
      wbank_q  <= 1'b0;
      rs_q     <= R_IDLE;
      rcnt_q   <= '0;
      rbank_q  <= 1'b0;
      rd_v_q   <= 1'b0;
      rd_idx_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      z_re_q   <= '0;
      z_im_q   <= '0;
      idx_q    <= '0;
    end else begin
      ws_q     <= ws_d;
      wcnt_q   <= wcnt_d;
      wbank_q  <= wbank_d;
      rs_q     <= rs_d;
      rcnt_q   <= rcnt_d;
      rbank_q  <= rbank_d;
      rd_v_q   <= rd_v_d;
      rd_idx_q <= rd_idx_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
      z_re_q   <= z_re_d;
      z_im_q   <= z_im_d;
      idx_q    <= idx_d;
    end
  end

  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign frame_err_o = err_q;
  assign z_re_o      = z_re_q;
  assign z_im_o      = z_im_q;
  assign idx_o       = idx_q;

endmodule

// File: tb/tb_fft_bit_rev_reorder.sv
// Scoreboard bench for fft_bit_rev_reorder (N=8): a frame-level model predicts each
// natural-order output, its index and the cycle it must appear in.
module tb_fft_bit_rev_reorder;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  logic valid_i = 1'b0, start_i = 1'b0;
  logic signed [W-1:0] x_re_i = '0, x_im_i = '0;
  logic valid_o, last_o, frame_err_o;
  logic signed [W-1:0] z_re_o, z_im_o;
  logic [AW-1:0] idx_o;

  fft_bit_rev_reorder #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .arst_n(arst_n), .valid_i(valid_i), .start_i(start_i),
    .x_re_i(x_re_i), .x_im_i(x_im_i), .valid_o(valid_o), .z_re_o(z_re_o),
    .z_im_o(z_im_o), .idx_o(idx_o), .last_o(last_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    int                  idx;
    bit                  last;
    int                  due;
  } exp_t;

  exp_t sb[$];
  int checks = 0, passes = 0, cyc = 0;
  bit exp_err = 0, in_frame = 0;
  logic signed [W-1:0] fr_re[$], fr_im[$];

  // Reverse the binary digits of p by repeated division.
  function automatic int rev(input int p);
    int r = 0, v = p;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Reference model: gather accepted samples into a frame, emit the natural-order list.
  initial forever begin
    @(posedge clk or negedge arst_n);
    if (!arst_n) begin
      sb.delete(); fr_re.delete(); fr_im.delete();
      in_frame = 0; exp_err = 0;
    end else begin
      cyc++;
      exp_err = 0;
      if (valid_i) begin
        if (start_i) begin
          if (in_frame) exp_err = 1;
          fr_re.delete(); fr_im.delete();
          fr_re.push_back(x_re_i); fr_im.push_back(x_im_i);
          in_frame = 1;
        end else if (in_frame) begin
          fr_re.push_back(x_re_i); fr_im.push_back(x_im_i);
        end
        if (in_frame && fr_re.size() == N) begin
          for (int k = 0; k < N; k++)
            for (int p = 0; p < N; p++)
              if (rev(p) == k) begin
                exp_t e;
                e.re = fr_re[p]; e.im = fr_im[p]; e.idx = k;
                e.last = (k == N - 1); e.due = cyc + 2 + k;
                sb.push_back(e);
              end
          in_frame = 0;
        end
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (arst_n) begin
      if (valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL spurious_valid cyc=%0d idx=%0d re=%0d (no output expected)", cyc, idx_o, z_re_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (z_re_o == e.re && z_im_o == e.im && int'(idx_o) == e.idx &&
              last_o == e.last && cyc == e.due)
            passes++;
          else
            $display("FAIL out_sample got re=%0d im=%0d idx=%0d last=%0d cyc=%0d want re=%0d im=%0d idx=%0d last=%0d cyc=%0d",
                     z_re_o, z_im_o, idx_o, last_o, cyc, e.re, e.im, e.idx, e.last, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        $display("FAIL missing_valid cyc=%0d got valid_o=0 want idx=%0d at cyc=%0d", cyc, sb[0].idx, sb[0].due);
        void'(sb.pop_front());
      end
      if (frame_err_o || exp_err) begin
        checks++;
        if (frame_err_o == exp_err) passes++;
        else $display("FAIL frame_err cyc=%0d got %0d want %0d", cyc, frame_err_o, exp_err);
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if (!valid_o && !last_o && !frame_err_o && z_re_o == 0 && z_im_o == 0 && idx_o == 0)
      passes++;
    else
      $display("FAIL %s got valid=%0d last=%0d err=%0d re=%0d im=%0d idx=%0d want all 0",
               name, valid_o, last_o, frame_err_o, z_re_o, z_im_o, idx_o);
  endtask

  task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im, input bit st);
    valid_i = 1'b1; start_i = st; x_re_i = re; x_im_i = im;
    @(posedge clk); #1;
    valid_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send(W'($urandom), W'($urandom), i == 0);
    end
  endtask

  task automatic drain_wait();
    int t = 0;
    while (sb.size() > 0 && t < 200) begin @(posedge clk); t++; end
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout got %0d pending outputs want 0", sb.size());
      sb.delete();
    end
    idle(3);
  endtask

  task automatic do_reset();
    #1 arst_n = 1'b0;
    #1 check_reset_outputs("reset_outputs");
    idle(3);
    arst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    int t;
    do_reset();

    for (int i = 0; i < N; i++) begin
      logic signed [W-1:0] v;
      v = W'(rev(i));
      send(v, v, i == 0);
    end
    drain_wait();

    repeat (3) send_frame(0);
    drain_wait();

    repeat (2) send_frame(1);
    drain_wait();

    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), i == 0);
    send_frame(0);
    drain_wait();

    do_reset();
    for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), 0);
    idle(12);
    send_frame(1);
    drain_wait();

    send_frame(0);
    t = 0;
    do begin @(negedge clk); t++; end while (!(valid_o && idx_o == 3) && t < 100);
    if (t >= 100) begin
      checks++;
      $display("FAIL mid_drain_wait got no idx_o=3 within 100 cycles want idx_o=3");
    end
    #2 arst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_drain");
    idle(2);
    arst_n = 1'b1;
    idle(20);
    send_frame(0);
    drain_wait();

    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < int'($urandom_range(1, 6)); i++) send(W'($urandom), W'($urandom), i == 0);
      send_frame($urandom_range(0, 1) == 1);
    end
    drain_wait();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
